// File: rtl/fpu_pkg.sv
// Shared types and defaults for the FP writeback buffer slice.
package fpu_pkg;

  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned RD_W_DEF  = 5;
  // Stored rd field is sized for the widest supported register index; RD_W must not exceed it.
  localparam int unsigned RD_W_MAX  = 8;

  typedef logic [31:0] fp_word_t;

  typedef struct packed {
    logic [RD_W_MAX-1:0] rd;
    fp_word_t            data;
  } entry_t;

endpackage

// File: rtl/fpu_fwd_sel.sv
// Forwarding match-and-select over the buffered results; youngest occupied match wins.
module fpu_fwd_sel
  import fpu_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned RD_W  = RD_W_DEF
) (
  input  entry_t                     entries_i [DEPTH],
  input  logic [DEPTH-1:0]           occ_i,
  input  logic [$clog2(DEPTH)-1:0]   head_i,
  input  logic [RD_W-1:0]            rs_i,
  output logic                       hit_o,
  output fp_word_t                   data_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW-1:0] idx;

  // Walk oldest to youngest so a later (younger) match overrides an earlier one.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_i + PtrW'(i);
      if (occ_i[idx] && (entries_i[idx].rd == RD_W_MAX'(rs_i))) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/fpu_wb_buffer.sv
// FIFO of fsqrt results awaiting the FP register-file write port, with operand forwarding.
module fpu_wb_buffer
  import fpu_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned RD_W  = RD_W_DEF
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [RD_W-1:0]          in_rd,
  input  logic [31:0]              in_data,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [RD_W-1:0]          wb_rd,
  output logic [31:0]              wb_data,
  input  logic [RD_W-1:0]          fwd_rs,
  output logic                     fwd_hit,
  output logic [31:0]              fwd_data,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  entry_t          mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;
  logic [DEPTH-1:0] occ;
  logic [PtrW-1:0]  off;

  assign in_ready = (count_q < CntW'(DEPTH));
  assign wb_valid = (count_q != '0);
  assign push     = in_valid & in_ready;
  assign pop      = wb_valid & wb_ready;
  assign wb_rd    = RD_W'(mem_q[rd_ptr_q].rd);
  assign wb_data  = mem_q[rd_ptr_q].data;
  assign count    = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Slot j is live when its distance from the head is below the occupancy count.
  always_comb begin
    occ = '0;
    off = '0;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      off    = PtrW'(j) - rd_ptr_q;
      occ[j] = ({1'b0, off} < count_q);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push && !flush) mem_q[wr_ptr_q] <= '{rd: RD_W_MAX'(in_rd), data: in_data};
    end
  end

  fpu_fwd_sel #(
    .DEPTH(DEPTH),
    .RD_W (RD_W)
  ) u_fwd_sel (
    .entries_i(mem_q),
    .occ_i    (occ),
    .head_i   (rd_ptr_q),
    .rs_i     (fwd_rs),
    .hit_o    (fwd_hit),
    .data_o   (fwd_data)
  );

endmodule
